hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Decode-stage hazard controller for the 5-stage pipeline.
- Detects load-use hazards against the X-stage instruction.
- Tracks one outstanding multi-cycle mult/div operation and its destination register; stalls any decode instruction that reads or writes that register until the result is written back.
- Drives the F/D freeze and D/X bubble controls; flags a sticky error on multdiv timeout or protocol violation.

Parameters:
MD_TIMEOUT, 40, max cycles from md_start to md_ready before timeout_err asserts
CNT_W, 6, width of multdiv cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT

Ports:
clock  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
d_rs  input  5  decode source register A
d_rt  input  5  decode source register B
d_rd  input  5  decode destination register
d_uses_rs  input  1  decode instruction reads d_rs
d_uses_rt  input  1  decode instruction reads d_rt
d_writes_rd  input  1  decode instruction writes d_rd
d_is_md  input  1  decode instruction is mult/div
x_valid  input  1  X stage holds a real instruction (not a bubble)
x_is_load  input  1  X instruction is lw
x_rd  input  5  X destination register
md_start  input  1  mult/div issued from X this cycle
md_rd  input  5  destination register of issued mult/div
md_ready  input  1  multdiv unit result valid (1-cycle pulse)
stall_fd  output  1  hold PC and F/D latch
bubble_dx  output  1  load nop into D/X latch
md_busy  output  1  multdiv outstanding (registered)
md_pending_rd  output  5  captured mult/div destination (registered)
md_wb  output  1  write pending result to md_pending_rd this cycle
timeout_err  output  1  sticky error flag

Behaviour:
- Register match rule: two 5-bit fields match iff equal AND non-zero; register 0 never matches anything.
- Reset (async, immediate): state IDLE; md_busy=0, md_pending_rd=0, counter=0, timeout_err=0. stall_fd=bubble_dx=md_wb=0 while reset is high.
- States: IDLE, BUSY, WB (2-bit encoding from the package).
- IDLE: md_start -> capture md_rd into md_pending_rd, counter=0, go BUSY. md_ready is ignored.
- BUSY: counter increments each cycle, saturating. md_ready -> go WB. When counter reaches MD_TIMEOUT with no md_ready: set timeout_err and remain in BUSY.
- WB (exactly 1 cycle): md_wb=1.
  - md_start in the same cycle: capture the new rd, counter=0, go BUSY.
  - Otherwise go IDLE; md_pending_rd keeps its value.
- md_busy=1 in BUSY and WB.
- md_start in BUSY: protocol violation; set timeout_err, ignore the start (state and rd unchanged).
- Load-use hazard (combinational): x_valid & x_is_load & ((d_uses_rs & match(d_rs,x_rd)) | (d_uses_rt & match(d_rt,x_rd))).
- Multdiv hazard (combinational), active in BUSY or WB when any of these holds:
  - d_uses_rs & match(d_rs,md_pending_rd)
  - d_uses_rt & match(d_rt,md_pending_rd)
  - d_writes_rd & match(d_rd,md_pending_rd) (WAW)
  - d_is_md (structural)
- Stall release is one cycle after WB: the consumer reads the register file after the write lands.
- stall_fd = bubble_dx = load_use | md_hazard. Both are combinational from state, registered fields and decode inputs; no input-to-output path through md_ready.
- Load-use stall lasts exactly 1 cycle, because the bubble makes x_valid=0 on the next cycle.
- timeout_err clears only on reset.

Decomposition:
- Package hazard_pkg:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, WB=2'd2)
  - REG_W=5
  - REG_ZERO=5'd0
- Sub-module reg_match:
  - 5-bit equality with zero-suppression.
  - Instantiated 5 times: rs/x, rt/x, rs/md, rt/md, rd/md.

Test Plan:
- Load-use: x_valid=1, x_is_load=1, x_rd=5'd8; d_rs=8, d_uses_rs=1 -> stall_fd=bubble_dx=1 for that cycle. Next cycle x_valid=0 -> both 0. Same stimulus with x_rd=0, d_rs=0 -> no stall.
- Multdiv RAW: md_start, md_rd=12. Hold d_rt=12, d_uses_rt=1. md_ready pulse 10 cycles later -> stall high from the cycle after start through WB. md_wb=1 in exactly one cycle. Stall low the cycle after WB; md_busy falls with it.
- Multdiv to r0: md_start with md_rd=0, d_rs=0 -> md_busy=1 but stall_fd=0 (unless d_is_md=1, which stalls).
- Back-to-back: md_start asserted in the WB cycle with md_rd=3 -> state BUSY, md_pending_rd=3, counter=0, md_busy stays 1 with no gap.
- Timeout/violation:
  - No md_ready for 40 cycles after start -> timeout_err=1, stays in BUSY.
  - Separately, md_start while BUSY -> timeout_err=1, md_pending_rd unchanged.
  - Reset mid-BUSY -> all outputs 0 immediately (before the next edge).
- WAW and structural: in BUSY with md_pending_rd=7: d_writes_rd=1 with d_rd=7 -> stall; d_is_md=1 with unrelated registers -> stall; d_rd=6 with no reads -> no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller: register-field
// width, the zero register, and the mult/div tracker state encoding.
package hazard_pkg;

  localparam int               REG_W    = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_e;

endpackage

// File: rtl/reg_match.sv
// Register-field comparator. r0 is hardwired to zero, so it never creates a
// dependency and must never match anything.
module reg_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] a_i,
  input  logic [REG_W-1:0] b_i,
  output logic             match_o
);

  assign match_o = (a_i == b_i) && (a_i != REG_ZERO);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use detection against X plus a tracker
// for one outstanding mult/div whose destination blocks decode until written back.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic             d_writes_rd,
  input  logic             d_is_md,
  input  logic             x_valid,
  input  logic             x_is_load,
  input  logic [REG_W-1:0] x_rd,
  input  logic             md_start,
  input  logic [REG_W-1:0] md_rd,
  input  logic             md_ready,
  output logic             stall_fd,
  output logic             bubble_dx,
  output logic             md_busy,
  output logic [REG_W-1:0] md_pending_rd,
  output logic             md_wb,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT);

  md_state_e        state_q, state_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic rs_x_match, rt_x_match, rs_md_match, rt_md_match, rd_md_match;
  logic load_use, md_hazard;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= REG_ZERO;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          rd_d    = md_rd;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // A second issue while one is in flight cannot be tracked; flag and drop it.
        if (md_start) err_d = 1'b1;
        if (md_ready)                  state_d = WB;
        else if (cnt_q >= TIMEOUT_CNT) err_d   = 1'b1;
      end
      WB: begin
        if (md_start) begin
          rd_d    = md_rd;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  reg_match u_rs_x  (.a_i(d_rs), .b_i(x_rd), .match_o(rs_x_match));
  reg_match u_rt_x  (.a_i(d_rt), .b_i(x_rd), .match_o(rt_x_match));
  reg_match u_rs_md (.a_i(d_rs), .b_i(rd_q), .match_o(rs_md_match));
  reg_match u_rt_md (.a_i(d_rt), .b_i(rd_q), .match_o(rt_md_match));
  reg_match u_rd_md (.a_i(d_rd), .b_i(rd_q), .match_o(rd_md_match));

  // Hazard held through WB so the consumer reads the register file after the write.
  always_comb begin
    load_use  = x_valid && x_is_load &&
                ((d_uses_rs && rs_x_match) || (d_uses_rt && rt_x_match));
    md_hazard = (state_q != IDLE) &&
                ((d_uses_rs && rs_md_match) || (d_uses_rt && rt_md_match) ||
                 (d_writes_rd && rd_md_match) || d_is_md);
    stall_fd      = !reset && (load_use || md_hazard);
    bubble_dx     = stall_fd;
    md_busy       = (state_q != IDLE);
    md_wb         = (state_q == WB);
    md_pending_rd = rd_q;
    timeout_err   = err_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model,
// a negedge monitor pops and compares against the DUT.
module tb_hazard_stall_unit;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_rd, x_rd, md_rd;
  logic       d_uses_rs, d_uses_rt, d_writes_rd, d_is_md;
  logic       x_valid, x_is_load, md_start, md_ready;
  logic       stall_fd, bubble_dx, md_busy, md_wb, timeout_err;
  logic [4:0] md_pending_rd;

  always #5 clock = ~clock;

  hazard_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .d_writes_rd(d_writes_rd), .d_is_md(d_is_md),
    .x_valid(x_valid), .x_is_load(x_is_load), .x_rd(x_rd),
    .md_start(md_start), .md_rd(md_rd), .md_ready(md_ready),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .md_busy(md_busy),
    .md_pending_rd(md_pending_rd), .md_wb(md_wb), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [4:0] d_rs, d_rt, d_rd;
    logic       uses_rs, uses_rt, writes_rd, is_md;
    logic       x_valid, x_is_load;
    logic [4:0] x_rd;
    logic       md_start;
    logic [4:0] md_rd;
    logic       md_ready;
  } stim_t;

  typedef struct {
    logic       stall;
    logic       busy;
    logic [4:0] pend;
    logic       wb;
    logic       err;
    bit         err_care;
  } exp_t;

  exp_t  exp_q[$];
  stim_t s;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Model: an operation is either awaiting its result or in its write-back
  // cycle; elapsed counts waiting cycles since issue.
  bit         m_waiting, m_writing, m_err, m_err_unk;
  logic [4:0] m_rd;
  int         m_elapsed;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit rmatch(logic [4:0] a, logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  task automatic clear_stim();
    s = '{default: '0};
  endtask

  task automatic apply();
    d_rs = s.d_rs; d_rt = s.d_rt; d_rd = s.d_rd;
    d_uses_rs = s.uses_rs; d_uses_rt = s.uses_rt;
    d_writes_rd = s.writes_rd; d_is_md = s.is_md;
    x_valid = s.x_valid; x_is_load = s.x_is_load; x_rd = s.x_rd;
    md_start = s.md_start; md_rd = s.md_rd; md_ready = s.md_ready;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_writing = 0; m_err = 0; m_err_unk = 0;
    m_rd = 5'd0; m_elapsed = 0;
  endtask

  // Called at posedge+1: drive, predict, consume one edge, advance the model.
  task automatic step();
    exp_t e;
    bit   lu, mh, active;
    apply();
    active = m_waiting || m_writing;
    lu = s.x_valid && s.x_is_load &&
         ((s.uses_rs && rmatch(s.d_rs, s.x_rd)) || (s.uses_rt && rmatch(s.d_rt, s.x_rd)));
    mh = active && ((s.uses_rs && rmatch(s.d_rs, m_rd)) || (s.uses_rt && rmatch(s.d_rt, m_rd)) ||
                    (s.writes_rd && rmatch(s.d_rd, m_rd)) || s.is_md);
    e.stall    = lu || mh;
    e.busy     = active;
    e.pend     = m_rd;
    e.wb       = m_writing;
    e.err      = m_err;
    e.err_care = m_err || !m_err_unk;
    exp_q.push_back(e);
    @(posedge clock);
    if (m_writing) begin
      m_writing = 0;
      if (s.md_start) begin
        m_waiting = 1; m_rd = s.md_rd; m_elapsed = 0;
      end
    end else if (m_waiting) begin
      if (s.md_start) m_err = 1;
      if (s.md_ready) begin
        m_waiting = 0; m_writing = 1;
      end else begin
        m_elapsed++;
        // Exact timeout edge is left a small tolerance window.
        if (m_elapsed >= MD_TIMEOUT + 3)      m_err = 1;
        else if (m_elapsed >= MD_TIMEOUT - 1) m_err_unk = 1;
      end
    end else if (s.md_start) begin
      m_waiting = 1; m_rd = s.md_rd; m_elapsed = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_stim();
    apply();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("stall_fd",      32'(stall_fd),      32'(e.stall));
        check("bubble_dx",     32'(bubble_dx),     32'(e.stall));
        check("md_busy",       32'(md_busy),       32'(e.busy));
        check("md_pending_rd", 32'(md_pending_rd), 32'(e.pend));
        check("md_wb",         32'(md_wb),         32'(e.wb));
        if (e.err_care) check("timeout_err", 32'(timeout_err), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    clear_stim(); step();

    // Load-use, its one-cycle release, and the r0 exemption.
    clear_stim(); s.x_valid = 1; s.x_is_load = 1; s.x_rd = 5'd8; s.d_rs = 5'd8; s.uses_rs = 1; step();
    s.x_valid = 0; step();
    s.x_valid = 1; s.x_rd = 5'd0; s.d_rs = 5'd0; step();

    // Multdiv RAW on r12 with the result ten cycles after issue.
    clear_stim(); s.md_start = 1; s.md_rd = 5'd12; s.d_rt = 5'd12; s.uses_rt = 1; step();
    s.md_start = 0;
    repeat (9) step();
    s.md_ready = 1; step();
    s.md_ready = 0; step();
    step();
    step();

    // Multdiv to r0: busy but no data stall, structural stall still applies.
    clear_stim(); s.md_start = 1; s.md_rd = 5'd0; s.d_rs = 5'd0; s.uses_rs = 1; step();
    s.md_start = 0; step();
    s.is_md = 1; step();
    s.is_md = 0; s.md_ready = 1; step();
    s.md_ready = 0; step();
    step();

    // WAW / structural / independent write, then back-to-back issue in WB.
    clear_stim(); s.md_start = 1; s.md_rd = 5'd7; step();
    clear_stim(); s.writes_rd = 1; s.d_rd = 5'd7; step();
    clear_stim(); s.is_md = 1; s.d_rs = 5'd1; s.d_rt = 5'd2; s.uses_rs = 1; s.uses_rt = 1; step();
    clear_stim(); s.writes_rd = 1; s.d_rd = 5'd6; step();
    clear_stim(); s.md_ready = 1; step();
    clear_stim(); s.md_start = 1; s.md_rd = 5'd3; s.d_rs = 5'd3; s.uses_rs = 1; step();
    s.md_start = 0; step();
    step();
    s.md_ready = 1; step();
    s.md_ready = 0; step();
    step();

    // Randomized traffic without protocol violations.
    for (int i = 0; i < 400; i++) begin
      clear_stim();
      s.d_rs      = 5'($urandom_range(0, 3));
      s.d_rt      = 5'($urandom_range(0, 3));
      s.d_rd      = 5'($urandom_range(0, 3));
      s.x_rd      = 5'($urandom_range(0, 3));
      s.md_rd     = 5'($urandom_range(0, 3));
      s.uses_rs   = 1'($urandom_range(0, 1));
      s.uses_rt   = 1'($urandom_range(0, 1));
      s.writes_rd = 1'($urandom_range(0, 1));
      s.is_md     = ($urandom_range(0, 3) == 0);
      s.x_valid   = 1'($urandom_range(0, 1));
      s.x_is_load = 1'($urandom_range(0, 1));
      s.md_start  = !m_waiting && ($urandom_range(0, 4) == 0);
      s.md_ready  = ($urandom_range(0, 7) == 0) || (m_waiting && ($urandom_range(0, 4) == 0));
      step();
    end

    // Timeout: no result for well beyond the limit; stays busy.
    do_reset();
    clear_stim(); s.md_start = 1; s.md_rd = 5'd9; step();
    clear_stim(); s.d_rs = 5'd9; s.uses_rs = 1;
    repeat (MD_TIMEOUT + 10) step();

    // Protocol violation: second issue while busy is flagged and dropped.
    do_reset();
    clear_stim(); s.md_start = 1; s.md_rd = 5'd9; step();
    clear_stim(); step();
    s.md_start = 1; s.md_rd = 5'd4; step();
    clear_stim(); s.d_rt = 5'd4; s.uses_rt = 1; step();
    s.md_ready = 1; step();
    s.md_ready = 0; step();
    step();

    // Asynchronous reset mid-busy clears every output before the next edge.
    do_reset();
    clear_stim(); s.md_start = 1; s.md_rd = 5'd5; step();
    clear_stim(); s.x_valid = 1; s.x_is_load = 1; s.x_rd = 5'd5; s.d_rs = 5'd5; s.uses_rs = 1; step();
    #2;
    reset = 1'b1;
    #1;
    check("rst_stall_fd",      32'(stall_fd),      32'd0);
    check("rst_bubble_dx",     32'(bubble_dx),     32'd0);
    check("rst_md_busy",       32'(md_busy),       32'd0);
    check("rst_md_pending_rd", 32'(md_pending_rd), 32'd0);
    check("rst_md_wb",         32'(md_wb),         32'd0);
    check("rst_timeout_err",   32'(timeout_err),   32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stim(); s.x_valid = 1; s.x_is_load = 1; s.x_rd = 5'd5; s.d_rs = 5'd5; s.uses_rs = 1; step();
    clear_stim(); step();

    repeat (2) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
